mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IF_BYTES, default 64, meaning bytes per instruction-cache block fill.
REQ-002 SHALL have parameter IO_MASK_HI, default 2'b11, meaning that addr[17:16]==IO_MASK_HI marks an I/O-mapped address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is asynchronous and active-low.
REQ-005 SHALL have port rdy, input, 1; when low, all registers hold their values.
REQ-006 SHALL have ports if_en (in, 1), if_pc (in, 32, 64-byte aligned), if_done (out, 1) and if_data (out, 8*IF_BYTES); these are the instruction-fetch block-read channel.
REQ-007 SHALL have ports lsb_en (in, 1), lsb_wr (in, 1, 1=store), lsb_addr (in, 32), lsb_len (in, 2: 0=1B, 1=2B, 2/3=4B), lsb_wdata (in, 32), lsb_done (out, 1) and lsb_rdata (out, 32); these are the load/store channel.
REQ-008 SHALL have port rob_clear, input, 1, a pipeline flush.
REQ-009 SHALL have ports mem_din (in, 8), mem_dout (out, 8), mem_a (out, 32), mem_wr (out, 1) and io_buffer_full (in, 1); these form the byte-wide RAM/IO port.

Function
REQ-010 SHALL implement states IDLE, IF_RD, LS_RD and LS_WR.
REQ-011 Arbitration: grant only in IDLE, only while both if_done and lsb_done are low.
- A sole requester is granted.
- If both request, grant the one not served last (last_grant flag).
REQ-012 At the grant edge:
- mem_a <= request address.
- Byte counter <= 0.
- last_grant updated.
- Next state IF_RD, LS_RD (lsb_wr=0) or LS_WR (lsb_wr=1).
REQ-013 Read timing: RAM returns mem_din one cycle after mem_a. For an N-byte read granted at edge E0:
- At edge Ek (k=1..N), byte k-1 is captured from mem_din.
- mem_a <= addr+k for k<N.
- At EN, done <= 1, mem_a <= 0, state <= IDLE.
REQ-014 Read data SHALL be little-endian: byte i goes to data bits [8i+7:8i].
- lsb_rdata bytes above N SHALL be zero (no sign extension).
- if_data and lsb_rdata SHALL hold until that channel's next completion.
REQ-015 Write timing: at E0, mem_wr <= 1 and mem_dout <= wdata[7:0]. Each later edge writes the next byte at addr+k. After the last byte is written, the next edge sets mem_wr <= 0, lsb_done <= 1 and state <= IDLE.
REQ-016 I/O write stall: while the current write address is I/O-mapped and io_buffer_full=1:
- mem_wr <= 0.
- The counter and address hold.
- The write resumes on the first edge with io_buffer_full=0.
REQ-017 if_done and lsb_done SHALL each be high for exactly one cycle per completed transaction.
REQ-018 IF abort: if if_en is low on any edge during IF_RD, go to IDLE with mem_a <= 0 and no if_done.
REQ-019 Flush: rob_clear during LS_RD aborts the load to IDLE with no lsb_done. rob_clear SHALL NOT abort LS_WR.
- Stores are committed and always complete.
- rob_clear in IF_RD aborts the fetch as in REQ-018.
- rob_clear in IDLE suppresses any grant on that edge.
REQ-020 mem_wr SHALL be 0 in every state other than LS_WR.
REQ-021 Address arithmetic SHALL be 32-bit modulo 2^32; wrap-around at 0xFFFFFFFF continues at 0x0.
REQ-022 The counter SHALL be wide enough for IF_BYTES (7 bits at the default).

Reset
REQ-023 While rst=0, the following SHALL be forced asynchronously: state=IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, counter=0, last_grant=LSB (so IF wins the first tie).
REQ-024 Reset assertion mid-transaction SHALL abandon it immediately with no done pulse. After release, the first grant follows REQ-011.

Verification
REQ-025 if_en=1, if_pc=0x1000, RAM byte i = i -> mem_a steps 0x1000..0x103F; if_done pulses 64 cycles after grant; if_data[7:0]=0x00, if_data[511:504]=0x3F.
REQ-026 Load lsb_addr=0x2002, len=1, RAM bytes 0xAA, 0xBB -> lsb_done 2 cycles after grant; lsb_rdata=0x0000BBAA.
REQ-027 Store lsb_addr=0x3000, len=2, wdata=0x11223344 -> mem_wr=1 for 4 consecutive cycles with mem_dout 0x44, 0x33, 0x22, 0x11 at 0x3000..0x3003; then lsb_done=1, mem_wr=0.
REQ-028 Both if_en and lsb_en asserted continuously from reset release -> IF is granted first, then LSB, then IF, alternating.
- No grant occurs in a cycle where a done is high.
REQ-029 Store to 0x30000, len=0, with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then is 1 for one cycle; lsb_done follows.
- Repeat with rob_clear asserted during the stall: the store still completes.
REQ-030 Load of 4 bytes, rob_clear on the 2nd byte -> state IDLE next edge; no lsb_done.
- Separately, rst=0 during an IF read -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction-fetch / load-store clients, the arbiter
// and the byte-wide RAM/IO port. The arbiter uses the slave view.
interface mem_arbiter_if #(
    parameter int IF_BYTES = 64
);
    logic                    if_en;
    logic [31:0]             if_pc;
    logic                    if_done;
    logic [8*IF_BYTES-1:0]   if_data;

    logic                    lsb_en;
    logic                    lsb_wr;
    logic [31:0]             lsb_addr;
    logic [1:0]              lsb_len;
    logic [31:0]             lsb_wdata;
    logic                    lsb_done;
    logic [31:0]             lsb_rdata;

    logic                    rob_clear;

    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [31:0]             mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;

    modport slave (
        input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
               rob_clear, mem_din, io_buffer_full,
        output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
               rob_clear, mem_din, io_buffer_full,
        input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-cache block fills and load/store accesses onto a
// single byte-wide RAM/IO port, one byte per cycle.
module mem_arbiter #(
    parameter int         IF_BYTES   = 64,
    parameter logic [1:0] IO_MASK_HI = 2'b11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(IF_BYTES + 1);
    localparam int IDX_W = (IF_BYTES > 1) ? $clog2(IF_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    // last_grant: 0 = instruction fetch served last, 1 = load/store served last
    localparam logic LAST_IF  = 1'b0;
    localparam logic LAST_LSB = 1'b1;

    state_t                state_q, state_d;
    logic [31:0]           mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d;
    logic                  lsb_done_q, lsb_done_d;
    logic [8*IF_BYTES-1:0] if_data_q, if_data_d;
    logic [8*IF_BYTES-1:0] if_buf_q, if_buf_d;
    logic [31:0]           lsb_rdata_q, lsb_rdata_d;
    logic [31:0]           ld_buf_q, ld_buf_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      nbytes_q, nbytes_d;
    logic                  last_grant_q, last_grant_d;

    logic                  can_grant, grant_if, grant_ls, last_byte;
    logic [CNT_W-1:0]      ls_bytes;
    logic [1:0]            nxt_lane;
    logic [31:0]           mem_a_inc;

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == IO_MASK_HI;
    endfunction

    assign can_grant = (state_q == IDLE) && !if_done_q && !lsb_done_q && !bus.rob_clear;
    assign grant_if  = can_grant && bus.if_en && (!bus.lsb_en || last_grant_q == LAST_LSB);
    assign grant_ls  = can_grant && bus.lsb_en && !grant_if;
    assign last_byte = (cnt_q == nbytes_q - CNT_W'(1));
    assign nxt_lane  = cnt_q[1:0] + 2'd1;
    assign mem_a_inc = mem_a_q + 32'd1;

    always_comb begin
        ls_bytes = CNT_W'(4);
        case (bus.lsb_len)
            2'd0:    ls_bytes = CNT_W'(1);
            2'd1:    ls_bytes = CNT_W'(2);
            default: ls_bytes = CNT_W'(4);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_data_d    = if_data_q;
        if_buf_d     = if_buf_q;
        lsb_rdata_d  = lsb_rdata_q;
        ld_buf_d     = ld_buf_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d      = IF_RD;
                    mem_a_d      = bus.if_pc;
                    cnt_d        = '0;
                    nbytes_d     = CNT_W'(IF_BYTES);
                    last_grant_d = LAST_IF;
                end else if (grant_ls) begin
                    mem_a_d      = bus.lsb_addr;
                    cnt_d        = '0;
                    nbytes_d     = ls_bytes;
                    wdata_d      = bus.lsb_wdata;
                    ld_buf_d     = '0;
                    last_grant_d = LAST_LSB;
                    if (bus.lsb_wr) begin
                        state_d    = LS_WR;
                        mem_dout_d = bus.lsb_wdata[7:0];
                        mem_wr_d   = !(is_io(bus.lsb_addr) && bus.io_buffer_full);
                    end else begin
                        state_d    = LS_RD;
                    end
                end
            end
            IF_RD: begin
                if (!bus.if_en || bus.rob_clear) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                end else begin
                    if_buf_d[{cnt_q[IDX_W-1:0], 3'b000} +: 8] = bus.mem_din;
                    if (last_byte) begin
                        if_data_d = if_buf_d;
                        if_done_d = 1'b1;
                        mem_a_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        mem_a_d = mem_a_inc;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            LS_RD: begin
                if (bus.rob_clear) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                end else begin
                    ld_buf_d[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
                    if (last_byte) begin
                        lsb_rdata_d = ld_buf_d;
                        lsb_done_d  = 1'b1;
                        mem_a_d     = '0;
                        state_d     = IDLE;
                    end else begin
                        mem_a_d = mem_a_inc;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            LS_WR: begin
                // A byte is committed on the edge that ends its mem_wr=1 cycle;
                // the I/O stall is evaluated only when issuing the next byte.
                if (mem_wr_q) begin
                    if (last_byte) begin
                        lsb_done_d = 1'b1;
                        mem_a_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        mem_a_d    = mem_a_inc;
                        mem_dout_d = wdata_q[{nxt_lane, 3'b000} +: 8];
                        mem_wr_d   = !(is_io(mem_a_inc) && bus.io_buffer_full);
                    end
                end else begin
                    mem_wr_d = !(is_io(mem_a_q) && bus.io_buffer_full);
                end
            end
            default: begin
                state_d = IDLE;
                mem_a_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= '0;
            if_buf_q     <= '0;
            lsb_rdata_q  <= '0;
            ld_buf_q     <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            last_grant_q <= LAST_LSB;
        end else if (rdy) begin
            state_q      <= state_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_data_q    <= if_data_d;
            if_buf_q     <= if_buf_d;
            lsb_rdata_q  <= lsb_rdata_d;
            ld_buf_q     <= ld_buf_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: stimulus queues expected completions and RAM writes; a
// negedge monitor pops and compares whenever the arbiter presents one.
module tb_mem_arbiter;
    localparam int IFB = 64;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   vectors = 0;
    int   miscompares = 0;

    logic [8*IFB-1:0] if_q[$];
    logic [31:0]      lsb_q[$];
    logic [39:0]      wr_q[$];
    logic [8*IFB-1:0] exp_if;

    mem_arbiter_if #(.IF_BYTES(IFB)) bus();

    mem_arbiter #(.IF_BYTES(IFB), .IO_MASK_HI(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (a == 32'h2002) return 8'hAA;
        if (a == 32'h2003) return 8'hBB;
        return a[7:0];
    endfunction

    assign bus.mem_din = ram_rd(bus.mem_a);

    task automatic chk(input string name, input logic [8*IFB-1:0] act, input logic [8*IFB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (bus.if_done) begin
                if (if_q.size() == 0) chk("if_done_unexpected", 1, 0);
                else chk("if_data", bus.if_data, if_q.pop_front());
            end
            if (bus.lsb_done) begin
                if (lsb_q.size() == 0) chk("lsb_done_unexpected", 1, 0);
                else chk("lsb_rdata", {480'b0, bus.lsb_rdata}, {480'b0, lsb_q.pop_front()});
            end
            if (bus.mem_wr) begin
                if (wr_q.size() == 0) chk("mem_wr_unexpected", 1, 0);
                else chk("mem_write", {472'b0, bus.mem_a, bus.mem_dout}, {472'b0, wr_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < IFB; i++) exp_if[i*8 +: 8] = 8'(i);
        rst = 1'b0; rdy = 1'b1;
        bus.if_en = 0; bus.if_pc = 0; bus.lsb_en = 0; bus.lsb_wr = 0;
        bus.lsb_addr = 0; bus.lsb_len = 0; bus.lsb_wdata = 0;
        bus.rob_clear = 0; bus.io_buffer_full = 0;
        tick(); tick();
        chk("rst_mem_a", bus.mem_a, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_dout", bus.mem_dout, 0);
        chk("rst_dones", {bus.if_done, bus.lsb_done}, 0);
        chk("rst_if_data", bus.if_data, 0);
        chk("rst_lsb_rdata", bus.lsb_rdata, 0);
        rst = 1'b1;
        tick();

        // 64-byte instruction block fill from 0x1000
        if_q.push_back(exp_if);
        bus.if_pc = 32'h1000; bus.if_en = 1;
        tick();
        chk("if_grant_a", bus.mem_a, 32'h1000);
        for (int k = 1; k < IFB; k++) begin
            tick();
            chk($sformatf("if_a_%0d", k), bus.mem_a, 32'h1000 + k);
        end
        chk("if_no_early_done", bus.if_done, 0);
        chk("if_mem_wr_low", bus.mem_wr, 0);
        tick();
        chk("if_done_pulse", bus.if_done, 1);
        chk("if_end_a", bus.mem_a, 0);
        bus.if_en = 0;
        tick();
        chk("if_done_one_cycle", bus.if_done, 0);

        // 2-byte load at 0x2002
        lsb_q.push_back(32'h0000BBAA);
        bus.lsb_addr = 32'h2002; bus.lsb_len = 1; bus.lsb_wr = 0; bus.lsb_en = 1;
        tick();
        chk("ld_grant_a", bus.mem_a, 32'h2002);
        bus.lsb_en = 0;
        tick();
        chk("ld_a1", bus.mem_a, 32'h2003);
        chk("ld_not_done", bus.lsb_done, 0);
        tick();
        chk("ld_done", bus.lsb_done, 1);
        tick();

        // 4-byte store at 0x3000
        foreach (wr_q[i]) wr_q.delete(i);
        wr_q.push_back({32'h3000, 8'h44}); wr_q.push_back({32'h3001, 8'h33});
        wr_q.push_back({32'h3002, 8'h22}); wr_q.push_back({32'h3003, 8'h11});
        lsb_q.push_back(32'h0000BBAA);
        bus.lsb_addr = 32'h3000; bus.lsb_len = 2; bus.lsb_wr = 1;
        bus.lsb_wdata = 32'h11223344; bus.lsb_en = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.lsb_en = 0;
            chk($sformatf("st_wr_%0d", k), bus.mem_wr, 1);
        end
        tick();
        chk("st_wr_end", bus.mem_wr, 0);
        chk("st_done", bus.lsb_done, 1);
        tick();

        // I/O store stalled by a full buffer, second pass with a flush in the stall
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] wb;
            wb = (pass == 0) ? 8'h5A : 8'hA5;
            wr_q.push_back({32'h30000, wb});
            lsb_q.push_back(32'h0000BBAA);
            bus.lsb_addr = 32'h30000; bus.lsb_len = 0; bus.lsb_wr = 1;
            bus.lsb_wdata = {24'h0, wb}; bus.io_buffer_full = 1; bus.lsb_en = 1;
            for (int k = 0; k < 3; k++) begin
                tick();
                bus.lsb_en = 0;
                if (pass == 1) bus.rob_clear = 1;
                chk($sformatf("io_stall_p%0d_%0d", pass, k), bus.mem_wr, 0);
            end
            bus.io_buffer_full = 0;
            tick();
            chk($sformatf("io_write_p%0d", pass), bus.mem_wr, 1);
            tick();
            chk($sformatf("io_done_p%0d", pass), bus.lsb_done, 1);
            chk($sformatf("io_wr_low_p%0d", pass), bus.mem_wr, 0);
            bus.rob_clear = 0;
            tick();
        end

        // 4-byte load flushed on its 2nd byte
        bus.lsb_addr = 32'h5020; bus.lsb_len = 2; bus.lsb_wr = 0; bus.lsb_en = 1;
        tick();
        bus.lsb_en = 0;
        tick();
        chk("flush_a1", bus.mem_a, 32'h5021);
        bus.rob_clear = 1;
        tick();
        bus.rob_clear = 0;
        chk("flush_idle_a", bus.mem_a, 0);
        tick();
        chk("flush_no_done", bus.lsb_done, 0);
        chk("flush_rdata_hold", bus.lsb_rdata, 32'h0000BBAA);

        // Address wrap with a rdy hold
        lsb_q.push_back(32'h000000FF);
        bus.lsb_addr = 32'hFFFFFFFF; bus.lsb_len = 1; bus.lsb_en = 1;
        tick();
        bus.lsb_en = 0; rdy = 0;
        tick();
        chk("rdy_hold_a", bus.mem_a, 32'hFFFFFFFF);
        rdy = 1;
        tick();
        chk("wrap_a", bus.mem_a, 32'h0);
        tick();
        chk("wrap_done", bus.lsb_done, 1);
        tick();

        // Both requesters from reset release: IF, LSB, IF
        rst = 0;
        tick();
        if_q.push_back(exp_if);
        lsb_q.push_back(32'h13121110);
        bus.if_pc = 32'h1000; bus.if_en = 1;
        bus.lsb_addr = 32'h4010; bus.lsb_len = 2; bus.lsb_wr = 0; bus.lsb_en = 1;
        rst = 1;
        tick();
        chk("alt_first_if", bus.mem_a, 32'h1000);
        for (int k = 1; k < IFB; k++) tick();
        tick();
        chk("alt_if_done", bus.if_done, 1);
        tick();
        chk("alt_no_grant_on_done", bus.mem_a, 0);
        tick();
        chk("alt_then_lsb", bus.mem_a, 32'h4010);
        for (int k = 1; k < 4; k++) tick();
        tick();
        chk("alt_lsb_done", bus.lsb_done, 1);
        tick();
        chk("alt_no_grant_on_done2", bus.mem_a, 0);
        tick();
        chk("alt_then_if", bus.mem_a, 32'h1000);
        bus.if_en = 0; bus.lsb_en = 0;
        tick();
        chk("if_abort_a", bus.mem_a, 0);
        tick();
        chk("if_abort_no_done", bus.if_done, 0);

        // Asynchronous reset during an IF read
        bus.if_en = 1;
        for (int k = 0; k < 5; k++) tick();
        rst = 0;
        #1;
        chk("arst_mem_a", bus.mem_a, 0);
        chk("arst_if_data", bus.if_data, 0);
        chk("arst_lsb_rdata", bus.lsb_rdata, 0);
        chk("arst_wr_done", {bus.mem_wr, bus.if_done, bus.lsb_done}, 0);
        bus.if_en = 0;
        tick();
        rst = 1;
        tick(); tick();

        chk("if_q_drained", if_q.size(), 0);
        chk("lsb_q_drained", lsb_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
